// File: rtl/mem_access_master_if.sv
// Request/response and memory-pin bundle for mem_access_master.
// master = the access block itself, slave = core plus memory side.
interface mem_access_master_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3,
        input  req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output resp_err, mem_read, mem_write,
        output mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3,
        output req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  resp_err, mem_read, mem_write,
        input  mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_master.sv
// Byte/half/word load-store initiator for a word-only data memory.
// Sub-word stores are performed as read-modify-write.
module mem_access_master #(
    parameter int ADDR_W = 32
) (
    input logic                clk,
    input logic                rst,
    mem_access_master_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic              r_err;
    logic [31:0]       r_word;

    logic              w_accept;
    logic              w_err;
    logic              w_bad_f3;
    logic              w_misal;
    logic [4:0]        w_lsb;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign bus.mem_addr = {r_addr[ADDR_W-1:2], 2'b00};

    always_comb begin
        w_bad_f3 = 1'b0;
        w_misal  = 1'b0;
        case (bus.req_funct3)
            3'b011, 3'b110, 3'b111: w_bad_f3 = 1'b1;
            default:                w_bad_f3 = 1'b0;
        endcase
        if (bus.req_we && bus.req_funct3[2])
            w_bad_f3 = 1'b1;
        if (bus.req_funct3[1:0] == 2'b01)
            w_misal = bus.req_addr[0];
        if (bus.req_funct3[1:0] == 2'b10)
            w_misal = (bus.req_addr[1:0] != 2'b00);
        w_err = w_bad_f3 || w_misal;
    end

    // Little-endian lane selection from the captured word.
    assign w_lsb  = {r_addr[1:0], 3'b000};
    assign w_byte = r_word[w_lsb +: 8];
    assign w_half = r_addr[1] ? r_word[31:16] : r_word[15:0];

    always_comb begin
        w_load = 32'd0;
        case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = r_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    always_comb begin
        w_merged = r_word;
        case (r_f3[1:0])
            2'b00: w_merged[w_lsb +: 8] = r_wdata[7:0];
            2'b01: begin
                if (r_addr[1])
                    w_merged[31:16] = r_wdata[15:0];
                else
                    w_merged[15:0] = r_wdata[15:0];
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_wdata  = 32'd0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = 32'd0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (w_err)
                        w_next = S_RESP;
                    else if (!bus.req_we)
                        w_next = S_ACCESS;
                    else if (bus.req_funct3[1:0] != 2'b10)
                        w_next = S_ACCESS;
                    else
                        w_next = S_WRITE;
                end
            end
            S_ACCESS: begin
                bus.mem_read = 1'b1;
                w_next = r_we ? S_WRITE : S_RESP;
            end
            S_WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_wdata = w_merged;
                w_next = S_RESP;
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = r_err;
                if (!r_err && !r_we)
                    bus.resp_rdata = w_load;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_f3    <= 3'd0;
            r_we    <= 1'b0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
            r_word  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_f3    <= bus.req_funct3;
                r_we    <= bus.req_we;
                r_wdata <= bus.req_wdata;
                r_err   <= w_err;
            end
            if (r_state == S_ACCESS)
                r_word <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_access_master.sv
// Directed self-checking bench for mem_access_master
// with a small word-wide memory model.
module tb_mem_access_master;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [31:0] mem [16];

    mem_access_master_if #(.ADDR_W(32)) bus ();

    mem_access_master #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    always @(posedge clk)
        if (bus.mem_write === 1'b1)
            mem[bus.mem_addr[5:2]] <= bus.mem_wdata;

    task automatic init_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[4] = 32'h8899AABB;
    endtask

    // Issue one request, then watch the bus until the response.
    task automatic do_req(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        output int          lat,
        output int          nrd,
        output int          nwr,
        output int          nbad,
        output logic [31:0] rd,
        output logic        er
    );
        lat = 0; nrd = 0; nwr = 0; nbad = 0;
        rd = 32'hX; er = 1'bX;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.req_addr  = 32'hFFFF_FFFF;
            bus.req_wdata = 32'h0;
            if (bus.mem_read === 1'b1) nrd++;
            if (bus.mem_write === 1'b1) nwr++;
            if ((bus.mem_read === 1'b1 || bus.mem_write === 1'b1)
                && bus.mem_addr !== {addr[31:2], 2'b00})
                nbad++;
            if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1)
                nbad++;
            if (bus.resp_valid === 1'b1) begin
                lat = c;
                rd  = bus.resp_rdata;
                er  = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0
            || bus.mem_write !== 1'b0 || bus.resp_valid !== 1'b0
            || bus.resp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: rdy=%b rd=%b wr=%b rv=%b re=%b want 1 0 0 0 0",
                bus.req_ready, bus.mem_read, bus.mem_write,
                bus.resp_valid, bus.resp_err);
        end
        vectors++;
        if (bus.resp_rdata !== 32'd0 || bus.mem_addr !== 32'd0
            || bus.mem_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0",
                bus.resp_rdata, bus.mem_addr, bus.mem_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad  [5] = '{32'h13, 32'h12, 32'h12, 32'h10, 32'h10};
        logic [31:0] exp [5] = '{32'hFFFFFF88, 32'h00000099,
                                 32'hFFFF8899, 32'h0000AABB,
                                 32'h8899AABB};
        int lat, nrd, nwr, nbad;
        logic [31:0] rd;
        logic er;
        init_mem();
        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, f3[i], ad[i], 32'h0,
                   lat, nrd, nwr, nbad, rd, er);
            vectors++;
            if (rd !== exp[i] || er !== 1'b0) begin
                miscompares++;
                $display("FAIL load%0d_data: got %h err %b want %h err 0",
                    i, rd, er, exp[i]);
            end
            vectors++;
            if (lat != 2 || nrd != 1 || nwr != 0 || nbad != 0) begin
                miscompares++;
                $display("FAIL load%0d_timing: lat=%0d rd=%0d wr=%0d bad=%0d want 2 1 0 0",
                    i, lat, nrd, nwr, nbad);
            end
        end
    endtask

    task automatic test_subword_store();
        int lat, nrd, nwr, nbad;
        logic [31:0] rd;
        logic er;
        init_mem();
        do_req(1'b1, 3'b000, 32'h11, 32'hFFFFFF5A,
               lat, nrd, nwr, nbad, rd, er);
        vectors++;
        if (lat != 3 || nrd != 1 || nwr != 1 || nbad != 0
            || er !== 1'b0 || rd !== 32'd0) begin
            miscompares++;
            $display("FAIL sb_timing: lat=%0d rd=%0d wr=%0d bad=%0d err=%b rdata=%h want 3 1 1 0 0 0",
                lat, nrd, nwr, nbad, er, rd);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0,
               lat, nrd, nwr, nbad, rd, er);
        vectors++;
        if (rd !== 32'h88995ABB) begin
            miscompares++;
            $display("FAIL sb_readback: got %h want 88995abb", rd);
        end
        do_req(1'b1, 3'b001, 32'h10, 32'h00001234,
               lat, nrd, nwr, nbad, rd, er);
        vectors++;
        if (lat != 3 || nrd != 1 || nwr != 1 || nbad != 0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sh_timing: lat=%0d rd=%0d wr=%0d bad=%0d err=%b want 3 1 1 0 0",
                lat, nrd, nwr, nbad, er);
        end
        do_req(1'b0, 3'b010, 32'h10, 32'h0,
               lat, nrd, nwr, nbad, rd, er);
        vectors++;
        if (rd !== 32'h88991234) begin
            miscompares++;
            $display("FAIL sh_readback: got %h want 88991234", rd);
        end
    endtask

    task automatic test_word_store();
        int lat, nrd, nwr, nbad;
        logic [31:0] rd;
        logic er;
        init_mem();
        do_req(1'b1, 3'b010, 32'h14, 32'hDEADBEEF,
               lat, nrd, nwr, nbad, rd, er);
        vectors++;
        if (lat != 2 || nrd != 0 || nwr != 1 || nbad != 0 || er !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_timing: lat=%0d rd=%0d wr=%0d bad=%0d err=%b want 2 0 1 0 0",
                lat, nrd, nwr, nbad, er);
        end
        do_req(1'b0, 3'b010, 32'h14, 32'h0,
               lat, nrd, nwr, nbad, rd, er);
        vectors++;
        if (rd !== 32'hDEADBEEF || mem[4] !== 32'h8899AABB) begin
            miscompares++;
            $display("FAIL sw_readback: got %h w10=%h want deadbeef 8899aabb",
                rd, mem[4]);
        end
    endtask

    task automatic test_errors();
        logic        we [3] = '{1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
        logic [31:0] ad [3] = '{32'h12, 32'h11, 32'h10};
        int lat, nrd, nwr, nbad;
        logic [31:0] rd;
        logic er;
        init_mem();
        for (int i = 0; i < 3; i++) begin
            do_req(we[i], f3[i], ad[i], 32'hCAFEF00D,
                   lat, nrd, nwr, nbad, rd, er);
            vectors++;
            if (lat != 1 || er !== 1'b1 || rd !== 32'd0) begin
                miscompares++;
                $display("FAIL err%0d_resp: lat=%0d err=%b rdata=%h want 1 1 0",
                    i, lat, er, rd);
            end
            vectors++;
            if (nrd != 0 || nwr != 0 || mem[4] !== 32'h8899AABB) begin
                miscompares++;
                $display("FAIL err%0d_mem: rd=%0d wr=%0d w10=%h want 0 0 8899aabb",
                    i, nrd, nwr, mem[4]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int nwr = 0;
        int nrv = 0;
        init_mem();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h00000077;
        @(negedge clk);
        bus.req_valid = 1'b0;
        vectors++;
        if (bus.mem_read !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_access: mem_read=%b want 1", bus.mem_read);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.mem_read !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_async: mem_read=%b rdy=%b want 0 1",
                bus.mem_read, bus.req_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 2) rst = 1'b0;
            if (bus.mem_write === 1'b1) nwr++;
            if (bus.resp_valid === 1'b1) nrv++;
        end
        vectors++;
        if (nwr != 0 || nrv != 0 || bus.req_ready !== 1'b1
            || mem[4] !== 32'h8899AABB) begin
            miscompares++;
            $display("FAIL rstmid_abort: wr=%0d rv=%0d rdy=%b w10=%h want 0 0 1 8899aabb",
                nwr, nrv, bus.req_ready, mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0]  rdy;
        logic [6:0]  rv;
        logic [31:0] ld;
        rdy = '0;
        rv  = '0;
        ld  = '0;
        init_mem();
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h10;
        bus.req_wdata  = 32'h0;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            rdy[c] = bus.req_ready;
            rv[c]  = bus.resp_valid;
            if (c == 2) ld = bus.resp_rdata;
            if (c == 1) begin
                bus.req_we     = 1'b1;
                bus.req_addr   = 32'h14;
                bus.req_wdata  = 32'h12345678;
            end
            if (c == 4) bus.req_valid = 1'b0;
        end
        vectors++;
        if (rdy !== 7'b1001001 || rv !== 7'b0100100) begin
            miscompares++;
            $display("FAIL b2b_seq: rdy=%b rv=%b want 1001001 0100100",
                rdy, rv);
        end
        vectors++;
        if (ld !== 32'h8899AABB || mem[5] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL b2b_data: ld=%h w14=%h want 8899aabb 12345678",
                ld, mem[5]);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        init_mem();
        test_reset();
        test_loads();
        test_subword_store();
        test_word_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==",
            vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_access_master.md
# mem_access_master

Initiator for the word-wide data memory port. It accepts byte, halfword and word load/store requests from the core's memory stage and drives the memory's MemRead/MemWrite/addr/WriteData pins. It returns sign- or zero-extended load data. Sub-word stores are done as read-modify-write, because the memory only writes whole 32-bit words.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  — system clock, all state on rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `req_valid`  in  1  — core presents a request.
- `req_ready`  out  1  — block can accept; high only in IDLE.
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_funct3`  in  3  — RISC-V size code:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU;
  - stores: 000 SB, 001 SH, 010 SW.
- `req_addr`  in  ADDR_W  — byte address.
- `req_wdata`  in  32  — store data, right-aligned.
- `resp_valid`  out  1  — one-cycle completion pulse.
- `resp_rdata`  out  32  — extended load data; 0 for stores and errors.
- `resp_err`  out  1  — misaligned or illegal funct3; qualified by `resp_valid`.
- `mem_read`  out  1  — memory read enable; read data is combinational, same cycle.
- `mem_write`  out  1  — memory write enable; word written at the next rising edge.
- `mem_addr`  out  ADDR_W  — always word-aligned: {req_addr[ADDR_W-1:2], 2'b00}.
- `mem_wdata`  out  32  — full word to write.
- `mem_rdata`  in  32  — word returned by memory.

## Operation
- Request is accepted on a rising edge where `req_valid && req_ready`. Address, funct3, we and wdata are latched; later input changes are ignored.
- States:
  - **IDLE**: `req_ready=1`. On accept:
    - error → RESP;
    - load or sub-word store → ACCESS;
    - SW → WRITE.
  - **ACCESS**: `mem_read=1`; `mem_rdata` captured into a word register at the edge.
    - load → RESP;
    - SB/SH → WRITE.
  - **WRITE**: `mem_write=1`; `mem_wdata` = merged word (SB/SH) or latched wdata (SW). → RESP.
  - **RESP**: `resp_valid=1`, `resp_rdata`/`resp_err` valid. → IDLE. There is no response backpressure.
- Error conditions:
  - LH/LHU/SH with addr[0]=1;
  - LW/SW with addr[1:0]≠0;
  - funct3 ∈ {011,110,111};
  - store with funct3[2]=1.
- An error request makes no memory access; `resp_rdata=0`.
- Byte lanes are little-endian: lane n = word[8n+7:8n], with n = addr[1:0] for bytes and addr[1] selects the halfword.
- Load extraction:
  - LB/LH sign-extend from bit 7/15;
  - LBU/LHU zero-extend;
  - LW passes the word through.
- Store merge: the selected lane(s) are replaced with req_wdata[7:0] or [15:0]; other bytes come from the captured read word.
- `mem_read` and `mem_write` are never high in the same cycle, and are both low outside ACCESS/WRITE.

## Timing
- Latency from accept edge k:
  - error: `resp_valid` in cycle k+1;
  - load and SW: cycle k+2;
  - SB/SH: cycle k+3.
- Back-to-back: the next request can be accepted in the cycle after RESP, which is IDLE.
- `mem_addr`/`mem_wdata` are registered-stable for the whole ACCESS/WRITE cycle.
- Reset (`rst`=1, any time, asynchronous):
  - state → IDLE;
  - `mem_read`, `mem_write`, `resp_valid`, `resp_err` = 0;
  - `resp_rdata`, `mem_addr`, `mem_wdata` = 0;
  - `req_ready` = 1 once in IDLE.
- Reset asserted during ACCESS/WRITE aborts the request: no write pulse and no response. A reset coincident with a WRITE edge leaves the memory outcome undefined.
- `req_valid` during non-IDLE states is ignored (`req_ready=0`).

## Test plan
Memory word 0x10 = 0x8899AABB for all scenarios.
- **Loads:**
  - LB 0x13 → 0xFFFFFF88;
  - LBU 0x12 → 0x00000099;
  - LH 0x12 → 0xFFFF8899;
  - LHU 0x10 → 0x0000AABB;
  - LW 0x10 → 0x8899AABB.
  - Each completes with `resp_valid` at k+2, `resp_err=0`, and exactly one `mem_read` cycle with `mem_addr=0x10`.
- **Sub-word stores** (a subsequent LW 0x10 must return the value):
  - SB 0x11, wdata 0xFFFFFF5A → word 0x88995ABB;
  - then SH 0x10, wdata 0x00001234 → 0x88991234.
  - Each store: one read cycle then one write cycle, `resp_valid` at k+3.
- **Word store:** SW 0x14, wdata 0xDEADBEEF → single `mem_write` cycle with no `mem_read`; `resp_valid` at k+2; LW 0x14 = 0xDEADBEEF.
- **Errors:**
  - LW 0x12 → `resp_err=1`;
  - SH 0x11 → `resp_err=1`;
  - load funct3=011 → `resp_err=1`.
  - Each: `resp_valid` at k+1, `resp_rdata=0`, no mem_read/mem_write ever asserted, word 0x10 unchanged.
- **Reset mid-operation:** assert `rst` during ACCESS of SB 0x10 → `mem_write` never pulses, no `resp_valid`, `req_ready=1` after release, word 0x10 still 0x8899AABB.
- **Back-to-back:** hold `req_valid` high with LW 0x10 then SW 0x14 → accepts exactly at IDLE cycles; second request accepted the cycle after the first RESP.
